// File: rtl/qar_arb_pkg.sv
// Shared types and constants for the qar_core unified-memory arbiter.
package qar_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned DATA_WIDTH       = 32;

endpackage

// File: rtl/qar_arb_starve_ctr.sv
// Saturating count of consecutive cycles a fetch has waited without completing.
module qar_arb_starve_ctr #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 at_limit
);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign at_limit = (cnt >= limit);

endmodule

// File: rtl/qar_mem_arbiter.sv
// Shares one valid/ready memory port between qar_core fetch (i_*) and data (d_*).
// Optional macro QAR_ARB_PERF_EN adds grant/conflict performance counters.
module qar_mem_arbiter
  import qar_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_valid,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_valid,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata
`ifdef QAR_ARB_PERF_EN
  ,
  output logic [31:0]           perf_i_grants,
  output logic [31:0]           perf_d_grants,
  output logic [31:0]           perf_conflicts
`endif
);

  arb_state_t state;
  logic       starve;
  logic       win_d;
  logic       act;
  logic       sel;
  logic       done;

  // Data wins ties unless fetch has waited long enough.
  assign win_d = d_valid && (!i_valid || !starve);

  always_comb begin
    act = 1'b0;
    sel = REQ_D;
    case (state)
      ARB_IDLE: begin
        act = i_valid || d_valid;
        sel = win_d ? REQ_D : REQ_I;
      end
      ARB_LOCK_I: begin
        act = 1'b1;
        sel = REQ_I;
      end
      ARB_LOCK_D: begin
        act = 1'b1;
        sel = REQ_D;
      end
      default: begin
        act = 1'b0;
        sel = REQ_D;
      end
    endcase
  end

  // Reset gating keeps the memory request dead the instant rst rises.
  assign m_valid = act && !rst;
  assign m_we    = m_valid && (sel == REQ_D) && d_we;
  assign m_addr  = rst ? '0 : ((sel == REQ_D) ? d_addr : i_addr);
  assign m_wdata = (m_valid && (sel == REQ_D)) ? d_wdata : '0;

  assign done    = m_valid && m_ready;
  assign i_ready = done && (sel == REQ_I);
  assign d_ready = done && (sel == REQ_D);
  assign i_rdata = rst ? '0 : m_rdata;
  assign d_rdata = rst ? '0 : m_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (act && !m_ready) begin
            state <= (sel == REQ_D) ? ARB_LOCK_D : ARB_LOCK_I;
          end
        end
        ARB_LOCK_I, ARB_LOCK_D: begin
          if (m_ready) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  qar_arb_starve_ctr #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (i_valid && !i_ready),
    .clr      (i_ready),
    .limit    (CNT_WIDTH'(STARVE_LIMIT)),
    .at_limit (starve)
  );

`ifdef QAR_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (i_ready) perf_i_grants <= perf_i_grants + 32'(1);
      if (d_ready) perf_d_grants <= perf_d_grants + 32'(1);
      if ((state == ARB_IDLE) && i_valid && d_valid) begin
        perf_conflicts <= perf_conflicts + 32'(1);
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // A locked requester must hold valid until its ready pulse.
  always @(posedge clk) begin
    if (!rst && (state == ARB_LOCK_I) && !i_valid) $error("qar_mem_arbiter: i_valid dropped while locked");
    if (!rst && (state == ARB_LOCK_D) && !d_valid) $error("qar_mem_arbiter: d_valid dropped while locked");
  end
`endif

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Scoreboard bench for qar_mem_arbiter with a variable-latency memory model.
module tb_qar_mem_arbiter;
  import qar_arb_pkg::*;

  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [31:0]   i_rdata;
  logic          d_valid;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ready;
  logic [31:0]   d_rdata;
  logic          m_valid;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_ready;
  logic [31:0]   m_rdata;
`ifdef QAR_ARB_PERF_EN
  logic [31:0]   perf_i_grants;
  logic [31:0]   perf_d_grants;
  logic [31:0]   perf_conflicts;
`endif

  qar_mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (4),
    .CNT_WIDTH    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_addr  (i_addr),
    .i_ready (i_ready),
    .i_rdata (i_rdata),
    .d_valid (d_valid),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ready (d_ready),
    .d_rdata (d_rdata),
    .m_valid (m_valid),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ready (m_ready),
    .m_rdata (m_rdata)
`ifdef QAR_ARB_PERF_EN
    ,
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  typedef struct {
    logic        is_d;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem [0:63];
  int          mem_wait = 0;
  int          lat_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int idx);
    return 32'hA000_0000 + 32'(idx);
  endfunction

  // Memory slave: ready after mem_wait stall cycles, reads combinational.
  assign m_ready = m_valid && (lat_cnt >= mem_wait);
  assign m_rdata = mem[m_addr[7:2]];

  always @(posedge clk) begin
    if (!m_valid || m_ready) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
    if (m_valid && m_ready && m_we) mem[m_addr[7:2]] <= m_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic chk, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.chk  = chk;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every completion must match the next expected grant.
  always @(negedge clk) begin
    if (!rst && (i_ready || d_ready)) begin
      check_val("one_ready", 32'(i_ready & d_ready), 32'd0);
      if (sb.size() == 0) begin
        check_val("sb_unexpected", 32'(d_ready), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("sb_src", 32'(d_ready), 32'(e.is_d));
        if (e.chk) check_val("sb_rdata", d_ready ? d_rdata : i_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n_i;
    for (int k = 0; k < 64; k++) mem[k] = init_word(k);
    rst = 1'b1; i_valid = 1'b1; i_addr = 32'h10;
    d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_i_ready", 32'(i_ready), 32'd0);
    check_val("rst_m_we", 32'(m_we), 32'd0);
    check_val("rst_i_rdata", i_rdata, 32'd0);
    check_val("rst_state", 32'(dut.state), 32'(ARB_IDLE));
    check_val("rst_cnt", 32'(dut.u_starve.cnt), 32'd0);
    i_valid = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Zero-wait fetch completes in the request cycle.
    i_valid = 1'b1; i_addr = 32'h10;
    push_exp(REQ_I, 1'b1, init_word(4));
    @(negedge clk);
    check_val("zw_i_ready", 32'(i_ready), 32'd1);
    check_val("zw_i_rdata", i_rdata, init_word(4));
    step();
    i_valid = 1'b0;
    check_val("zw_state", 32'(dut.state), 32'(ARB_IDLE));
    check_val("zw_cnt", 32'(dut.u_starve.cnt), 32'd0);

    // Tie with wait_cnt=0: data write wins, fetch follows.
    i_valid = 1'b1; i_addr = 32'h20;
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h48; d_wdata = 32'd2;
    push_exp(REQ_D, 1'b0, '0);
    push_exp(REQ_I, 1'b1, init_word(8));
    @(negedge clk);
    check_val("tie_d_ready", 32'(d_ready), 32'd1);
    check_val("tie_i_ready", 32'(i_ready), 32'd0);
    check_val("tie_m_we", 32'(m_we), 32'd1);
    check_val("tie_m_addr", m_addr, 32'h48);
    step();
    d_valid = 1'b0; d_we = 1'b0;
    check_val("tie_mem18", mem[18], 32'd2);
    check_val("tie_cnt", 32'(dut.u_starve.cnt), 32'd1);
    step();
    i_valid = 1'b0;

    // Starvation: fetch wins the 5th arbitration against constant data traffic.
    i_valid = 1'b1; i_addr = 32'h30;
    d_valid = 1'b1; d_addr = 32'h40;
    for (int k = 1; k <= 4; k++) push_exp(REQ_D, 1'b1, init_word(16));
    push_exp(REQ_I, 1'b1, init_word(12));
    push_exp(REQ_D, 1'b1, init_word(16));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_val($sformatf("starve_i_ready_%0d", k), 32'(i_ready), (k == 5) ? 32'd1 : 32'd0);
      step();
    end
    i_valid = 1'b0;
    check_val("starve_cnt", 32'(dut.u_starve.cnt), 32'd0);
    step();
    d_valid = 1'b0;

    // 3-cycle memory: lock holds the mux on fetch while data arrives.
    mem_wait = 2;
    i_valid = 1'b1; i_addr = 32'h14;
    push_exp(REQ_I, 1'b1, init_word(5));
    push_exp(REQ_D, 1'b1, init_word(17));
    n_i = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_val($sformatf("lat_m_addr_%0d", k), m_addr, 32'h14);
      check_val($sformatf("lat_d_ready_%0d", k), 32'(d_ready), 32'd0);
      if (i_ready) n_i++;
      step();
      if (k == 1) begin
        d_valid = 1'b1; d_addr = 32'h44;
      end
    end
    i_valid = 1'b0;
    check_val("lat_i_pulses", 32'(n_i), 32'd1);
    check_val("lat_state_idle", 32'(dut.state), 32'(ARB_IDLE));
    @(negedge clk);
    check_val("lat_d_addr", m_addr, 32'h44);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (d_ready) got = 1'b1;
      else @(negedge clk);
    end
    check_val("lat_d_done", 32'(got), 32'd1);
    step();
    d_valid = 1'b0;

    // Reset during LOCK_D aborts the request asynchronously.
    mem_wait = 100;
    i_valid = 1'b1; i_addr = 32'h18;
    d_valid = 1'b1; d_addr = 32'h44;
    step();
    check_val("abort_state", 32'(dut.state), 32'(ARB_LOCK_D));
    check_val("abort_m_valid", 32'(m_valid), 32'd1);
    check_val("abort_cnt", 32'(dut.u_starve.cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("abort_m_valid_rst", 32'(m_valid), 32'd0);
    check_val("abort_d_ready_rst", 32'(d_ready), 32'd0);
    i_valid = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    check_val("abort_state_after", 32'(dut.state), 32'(ARB_IDLE));
    check_val("abort_cnt_after", 32'(dut.u_starve.cnt), 32'd0);
    check_val("abort_m_valid_after", 32'(m_valid), 32'd0);
    mem_wait = 0;
    step();

`ifdef QAR_ARB_PERF_EN
    // Perf counters: 2 conflict cycles, 3 data grants, 10 fetch grants.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    i_valid = 1'b1; i_addr = 32'h8;
    d_valid = 1'b1; d_addr = 32'h4;
    push_exp(REQ_D, 1'b1, init_word(1));
    push_exp(REQ_D, 1'b1, init_word(1));
    step();
    step();
    i_valid = 1'b0;
    push_exp(REQ_D, 1'b1, init_word(1));
    step();
    d_valid = 1'b0;
    i_valid = 1'b1;
    for (int k = 0; k < 10; k++) push_exp(REQ_I, 1'b1, init_word(2));
    for (int k = 0; k < 10; k++) step();
    i_valid = 1'b0;
    step();
    check_val("perf_i", perf_i_grants, 32'd10);
    check_val("perf_d", perf_d_grants, 32'd3);
    check_val("perf_conf", perf_conflicts, 32'd2);
`endif

    step();
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/qar_mem_arbiter.md
Name: qar_mem_arbiter

Overview:
- Two-requester arbiter that shares one unified memory port between the qar_core instruction-fetch port (imem_*) and data port (mem_*).
- Sits between the core, built with USE_INTERNAL_IMEM=0 and USE_INTERNAL_DMEM=0, and a single SRAM or bus slave that has a valid/ready handshake.
- Data accesses take priority by default. A wait counter guarantees forward progress for fetch.
- Ready and read data pass through combinationally, so a zero-wait memory adds no latency.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- STARVE_LIMIT, 4, consecutive blocked fetch cycles after which fetch wins the next arbitration (1..255).
- CNT_WIDTH, 8, width of the fetch wait counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- i_valid  in  1  fetch request.
- i_addr  in  ADDR_WIDTH  fetch byte address.
- i_ready  out  1  fetch complete pulse.
- i_rdata  out  32  fetch data, valid while i_ready=1.
- d_valid  in  1  data request.
- d_we  in  1  data write enable.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  32  write data.
- d_ready  out  1  data complete pulse.
- d_rdata  out  32  read data, valid while d_ready=1.
- m_valid  out  1  request to memory.
- m_we  out  1  write enable to memory.
- m_addr  out  ADDR_WIDTH  address to memory.
- m_wdata  out  32  write data to memory.
- m_ready  in  1  memory completion.
- m_rdata  in  32  memory read data.

Behaviour:
- Clock and reset: single clock, clk. rst is asynchronous and active-high. While rst=1:
  - state=IDLE, wait_cnt=0.
  - m_valid, i_ready and d_ready are forced to 0. m_we=0. i_rdata and d_rdata are 0.
- Requester protocol:
  - A requester holds valid and its payload stable until it sees ready=1 for exactly one cycle.
  - The arbiter never asserts ready on a requester whose valid=0.
- States:
  - IDLE: no transfer is locked.
  - LOCK_I: fetch transfer outstanding.
  - LOCK_D: data transfer outstanding.
- Winner selection (combinational, used in IDLE only):
  - Only d_valid: winner = D.
  - Only i_valid: winner = I.
  - Both valid: winner = I if wait_cnt >= STARVE_LIMIT, otherwise winner = D.
- IDLE with any valid:
  - m_valid=1. m_we, m_addr and m_wdata are muxed from the winner. An I winner drives m_we=0 and m_wdata=0.
  - If m_ready=1 in the same cycle, the winner's ready=1 and its rdata=m_rdata. State stays IDLE (zero added latency).
  - Otherwise the next state is LOCK_I or LOCK_D.
- LOCK_x:
  - m_valid=1 and the mux stays fixed to x regardless of the other requester.
  - When m_ready=1, x_ready=1 and the next state is IDLE.
  - A new arbitration happens in the following cycle, never back-to-back within the lock.
- Locked requester drops valid (protocol violation): the arbiter keeps m_valid=1 until m_ready. A simulation-only $error is raised.
- wait_cnt:
  - Increments, saturating at 2^CNT_WIDTH-1, on each cycle where i_valid=1 and no fetch completes.
  - Clears to 0 on the cycle a fetch completes.
  - Holds when i_valid=0.
- Non-granted requester outputs: ready=0. rdata is driven as m_rdata but is not qualified.
- Reset mid-transfer: the lock is abandoned and m_valid falls immediately (asynchronous). The memory must tolerate an aborted request.

Optional Feature:
- Macro: QAR_ARB_PERF_EN.
- When defined, three extra output ports are added, each 32 bits wide, wrapping, and reset to 0:
  - perf_i_grants: +1 per fetch completion.
  - perf_d_grants: +1 per data completion.
  - perf_conflicts: +1 per IDLE cycle with i_valid & d_valid.
- When not defined, these ports and their registers do not exist and the functional behaviour is identical.

Decomposition:
- Package qar_arb_pkg holds:
  - the state enum {ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D};
  - the requester-id constants REQ_I and REQ_D;
  - the default STARVE_LIMIT.
- One sub-module, qar_arb_starve_ctr, holds the saturating wait counter. Its ports are inc, clr, limit and at_limit.
- The FSM and muxes stay in the top level.

Test Plan:
- Zero-wait memory (m_ready=m_valid), only i_valid, i_addr=0x10 -> i_ready in the same cycle and i_rdata equals memory word 4; state stays IDLE.
- Both valid, d_we=1, d_addr=0x48, d_wdata=2, wait_cnt=0 -> memory word 18 is written with 2 and d_ready=1; i_ready=0 that cycle; wait_cnt=1.
- d_valid held high continuously with i_valid high, STARVE_LIMIT=4 -> fetch is granted on the 5th arbitration; wait_cnt then reads 0.
- Memory with 3-cycle latency, fetch granted first, d_valid rises in the 2nd cycle -> the mux stays on I for 3 cycles, i_ready pulses once, and the data access is granted in the following IDLE cycle.
- rst asserted during LOCK_D with m_ready held low -> m_valid=0 immediately; after release, state is IDLE and wait_cnt=0.
- QAR_ARB_PERF_EN build, 10 fetches, 3 data accesses, 2 conflict cycles -> perf_i_grants=10, perf_d_grants=3, perf_conflicts=2.
